lector_7seg_mux: RTL and testbench
==================================

// Module: lector_7seg_mux
// PURPOSE
//  Reader/encoder side of the 7-segment display path: samples a scanned,
//  multiplexed display bus (segment lines + one-hot digit select) and recovers
//  each digit's 4-bit code, with per-digit stability filtering.
//  Sits between a scanned display driver (or its loopback tap) and checking/control
//  logic. Emits committed digits, per-digit valid flags and change/error pulses.
// PARAMETERS
//  N_DIG       4  number of multiplexed digits (anodos width)
//  STABLE_CNT  3  identical consecutive visits to a digit required to commit (>=1)
//  CNT_W       2  width of per-digit visit counter; must hold STABLE_CNT
// PORTS
//  clk          in   1        single clock
//  rst          in   1        synchronous, active-high reset
//  sample_en    in   1        qualifies segmentos/anodos this cycle
//  segmentos    in   7        [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g; 1 = lit
//  anodos       in   N_DIG    digit select; 1 = active; must be one-hot when sampled
//  digitos      out  4*N_DIG  committed code of digit i at [4i+3:4i]
//  valido       out  N_DIG    digit i holds a committed code in 0..9 or GUION
//  nuevo        out  1        1-cycle pulse: any committed code changed
//  error_anodo  out  1        1-cycle pulse: sampled anodos not one-hot
// BEHAVIOUR
//  Reset:
//   - Every digit goes to VACIO.
//   - digitos = all 4'hF; valido = 0; nuevo = 0; error_anodo = 0.
//   - Input stage cleared (sample_en_q = 0).
//  Stage 1: register sample_en, segmentos and anodos.
//  Stage 2: act on the registered sample. Outputs are registered, so they
//   update 2 cycles after the qualifying sample.
//  Encoding (segment pattern -> code; anything else -> 4'hF INVALIDO):
//   - 0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//   - 5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//   - 0000001 -> 4'hA GUION
//  anodos check:
//   - Zero or multiple bits set: sample ignored, no state changes, error_anodo pulses.
//   - One-hot: only digit i = index of the set bit is updated.
//  Per-digit FSM (code c, candidate cand, counter cnt):
//   - VACIO: cand = c, cnt = 1 -> CAPTURANDO. If STABLE_CNT == 1, commit now -> ESTABLE.
//   - CAPTURANDO, c == cand: cnt++. When cnt reaches STABLE_CNT: commit -> ESTABLE.
//   - CAPTURANDO, c != cand: cand = c, cnt = 1.
//   - ESTABLE, c == committed code: no change.
//   - ESTABLE, c != committed code: cand = c, cnt = 1 -> CAPTURANDO. Old output
//     and valido are held until the new code commits.
//  Commit:
//   - digitos[i] = cand; valido[i] = (cand != 4'hF).
//   - nuevo pulses only if cand differs from the previous committed code.
//   - Committing INVALIDO is legal: it clears valido[i].
//  Boundaries:
//   - sample_en = 0: no state change and no pulses; gaps do not break a streak.
//   - Counter saturates at STABLE_CNT, never wraps.
//   - nuevo and error_anodo cannot be set by the same sample.
//   - rst mid-capture discards all candidates/counters, overriding any same-cycle sample.
// STRUCTURE
//  Package pkg_7seg holds:
//   - segment pattern constants SEG_0..SEG_9 and SEG_GUION;
//   - COD_GUION = 4'hA, COD_INVALIDO = 4'hF;
//   - typedef enum {VACIO, CAPTURANDO, ESTABLE} estado_dig_t.
//  Sub-module codificador_7seg: combinational segmentos[6:0] -> code[3:0], one instance.
//  Per-digit FSM and counter are replicated with a generate loop.
// TESTING
//  1 Reset held 2 cycles -> digitos = 16'hFFFF, valido = 0, no pulses.
//  2 anodos = 0001, segmentos = 1111110 on 3 sampled cycles -> digitos[3:0] = 0,
//    valido[0] = 1, nuevo pulses, all 2 cycles after the 3rd sample.
//  3 Digit 2 sees 1011011, 1011011, 1111111, then 1011011 x3 -> code 5 commits
//    only after the final triple; no commit of 8.
//  4 anodos = 0011 or 0000 with sample_en = 1 -> error_anodo pulses; digitos and
//    valido unchanged.
//  5 Digit 1 sees 0000001 x3 -> code A, valido[1] = 1; then 1010101 x3 -> code F,
//    valido[1] = 0, nuevo pulses.
//  6 rst asserted after 2 of 3 matching samples, then 1 more sample ->
//    no commit; 3 fresh samples are needed.

Source files
------------

// File: rtl/lector_7seg_mux_pkg.sv
// Purpose: shared constants and types for the 7-segment reader path.
//   Segment patterns are ordered [6]=a .. [0]=g, 1 = lit.
package pkg_7seg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned COD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_GUION = 7'b0000001;

    localparam logic [COD_W-1:0] COD_GUION    = 4'hA;
    localparam logic [COD_W-1:0] COD_INVALIDO = 4'hF;

    typedef enum logic [1:0] {
        VACIO      = 2'd0,
        CAPTURANDO = 2'd1,
        ESTABLE    = 2'd2
    } estado_dig_t;

    // True when exactly one bit of v is set.
    function automatic logic es_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/lector_7seg_mux_if.sv
// Purpose: scanned display bus (input side) plus decoded results (output side).
//   master drives sample_en/segmentos/anodos and observes the results;
//   slave is the reader.
interface lector_7seg_mux_if
    import pkg_7seg::*;
#(
    parameter int unsigned N_DIG = 4
);
    logic                   sample_en;
    logic [SEG_W-1:0]       segmentos;
    logic [N_DIG-1:0]       anodos;
    logic [COD_W*N_DIG-1:0] digitos;
    logic [N_DIG-1:0]       valido;
    logic                   nuevo;
    logic                   error_anodo;

    modport master (
        output sample_en, segmentos, anodos,
        input  digitos, valido, nuevo, error_anodo
    );

    modport slave (
        input  sample_en, segmentos, anodos,
        output digitos, valido, nuevo, error_anodo
    );
endinterface

// File: rtl/lector_7seg_mux_codificador.sv
// Purpose: combinational segment pattern -> 4-bit code.
//   segmentos  in  7  [6]=a .. [0]=g
//   codigo_c   out 4  0..9, A for dash, F for anything unrecognised
module codificador_7seg
    import pkg_7seg::*;
(
    input  logic [SEG_W-1:0] segmentos,
    output logic [COD_W-1:0] codigo_c
);

    always_comb begin
        codigo_c = COD_INVALIDO;
        case (segmentos)
            SEG_0:     codigo_c = 4'h0;
            SEG_1:     codigo_c = 4'h1;
            SEG_2:     codigo_c = 4'h2;
            SEG_3:     codigo_c = 4'h3;
            SEG_4:     codigo_c = 4'h4;
            SEG_5:     codigo_c = 4'h5;
            SEG_6:     codigo_c = 4'h6;
            SEG_7:     codigo_c = 4'h7;
            SEG_8:     codigo_c = 4'h8;
            SEG_9:     codigo_c = 4'h9;
            SEG_GUION: codigo_c = COD_GUION;
            default:   codigo_c = COD_INVALIDO;
        endcase
    end

endmodule

// File: rtl/lector_7seg_mux.sv
// Purpose: recover per-digit codes from a scanned 7-segment bus with
//   stability filtering (a code must be seen STABLE_CNT consecutive visits).
//   clk, rst     clock and synchronous active-high reset
//   bus (slave)  sample_en/segmentos/anodos in; digitos/valido/nuevo/error_anodo out
// Outputs change two clock edges after the qualifying sample.
module lector_7seg_mux
    import pkg_7seg::*;
#(
    parameter int unsigned N_DIG      = 4,
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned CNT_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    lector_7seg_mux_if.slave   bus
);

    // Stage 1: input sample registers.
    logic                   sample_en_d, sample_en_q;
    logic [SEG_W-1:0]       segmentos_d, segmentos_q;
    logic [N_DIG-1:0]       anodos_d,    anodos_q;

    always_comb begin
        sample_en_d = bus.sample_en;
        segmentos_d = bus.segmentos;
        anodos_d    = bus.anodos;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_en_q <= 1'b0;
            segmentos_q <= '0;
            anodos_q    <= '0;
        end else begin
            sample_en_q <= sample_en_d;
            segmentos_q <= segmentos_d;
            anodos_q    <= anodos_d;
        end
    end

    // Stage 2: decode the registered sample and qualify the digit select.
    logic [COD_W-1:0] codigo_c;
    logic             onehot_c;
    logic             acepta_c;
    logic             error_c;

    codificador_7seg u_codificador (
        .segmentos (segmentos_q),
        .codigo_c  (codigo_c)
    );

    assign onehot_c = es_onehot(32'(anodos_q));
    assign acepta_c = sample_en_q & onehot_c;
    assign error_c  = sample_en_q & ~onehot_c;

    logic [COD_W*N_DIG-1:0] dig_bus;
    logic [N_DIG-1:0]       val_bus;
    logic [N_DIG-1:0]       cambio_bus;

    // Per-digit stability filter.
    for (genvar i = 0; i < N_DIG; i++) begin : g_dig
        estado_dig_t      estado_d, estado_q;
        logic [COD_W-1:0] cand_d,   cand_q;
        logic [CNT_W-1:0] cnt_d,    cnt_q;
        logic [COD_W-1:0] dig_d,    dig_q;
        logic             val_d,    val_q;
        logic             visita_c;
        logic             cambio_c;

        assign visita_c = acepta_c & anodos_q[i];

        always_comb begin
            estado_d = estado_q;
            cand_d   = cand_q;
            cnt_d    = cnt_q;
            dig_d    = dig_q;
            val_d    = val_q;
            cambio_c = 1'b0;
            if (visita_c) begin
                unique case (estado_q)
                    VACIO: begin
                        cand_d   = codigo_c;
                        cnt_d    = CNT_W'(1);
                        estado_d = CAPTURANDO;
                    end
                    CAPTURANDO: begin
                        if (codigo_c == cand_q) begin
                            // Saturate rather than wrap.
                            if (cnt_q < CNT_W'(STABLE_CNT)) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            cand_d = codigo_c;
                            cnt_d  = CNT_W'(1);
                        end
                    end
                    ESTABLE: begin
                        // Held output stays until the new code commits.
                        if (codigo_c != dig_q) begin
                            cand_d   = codigo_c;
                            cnt_d    = CNT_W'(1);
                            estado_d = CAPTURANDO;
                        end
                    end
                    default: begin
                        estado_d = VACIO;
                    end
                endcase
                // Commit once the streak length is reached (also covers STABLE_CNT == 1).
                if ((estado_d == CAPTURANDO) && (cnt_d >= CNT_W'(STABLE_CNT))) begin
                    estado_d = ESTABLE;
                    dig_d    = cand_d;
                    val_d    = (cand_d != COD_INVALIDO);
                    cambio_c = (cand_d != dig_q);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                estado_q <= VACIO;
                cand_q   <= COD_INVALIDO;
                cnt_q    <= '0;
                dig_q    <= COD_INVALIDO;
                val_q    <= 1'b0;
            end else begin
                estado_q <= estado_d;
                cand_q   <= cand_d;
                cnt_q    <= cnt_d;
                dig_q    <= dig_d;
                val_q    <= val_d;
            end
        end

        assign dig_bus[COD_W*i +: COD_W] = dig_q;
        assign val_bus[i]                = val_q;
        assign cambio_bus[i]             = cambio_c;
    end

    // Event pulses; a commit needs a one-hot select, so they never coincide.
    logic nuevo_d,       nuevo_q;
    logic error_anodo_d, error_anodo_q;

    always_comb begin
        nuevo_d       = |cambio_bus;
        error_anodo_d = error_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nuevo_q       <= 1'b0;
            error_anodo_q <= 1'b0;
        end else begin
            nuevo_q       <= nuevo_d;
            error_anodo_q <= error_anodo_d;
        end
    end

    assign bus.digitos     = dig_bus;
    assign bus.valido      = val_bus;
    assign bus.nuevo       = nuevo_q;
    assign bus.error_anodo = error_anodo_q;

endmodule

// File: tb/tb_lector_7seg_mux.sv
// Bench for lector_7seg_mux: directed scenarios plus randomized traffic,
// checked against a run-length model of the display reader.
module tb_lector_7seg_mux;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned STABLE = 3;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_BAD  = 7'b1010101;

    logic clk;
    logic rst;

    lector_7seg_mux_if #(.N_DIG(NDIG)) bus ();

    lector_7seg_mux #(
        .N_DIG      (NDIG),
        .STABLE_CNT (STABLE),
        .CNT_W      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: per digit, the current run of identical codes and the committed code.
    int         run_len [NDIG];
    logic [3:0] run_val [NDIG];
    logic [3:0] com     [NDIG];
    logic       p_en;
    logic [6:0] p_seg;
    logic [3:0] p_an;
    logic [15:0] exp_dig;
    logic [3:0]  exp_val;
    logic        exp_nuevo;
    logic        exp_err;
    logic [21:0] got_v;
    logic [21:0] exp_v;

    function automatic logic [3:0] ref_code(input logic [6:0] s);
        logic [3:0] c;
        c = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (s == SEG_TBL[k]) c = 4'(k);
        end
        if (s == SEG_DASH) c = 4'hA;
        return c;
    endfunction

    task automatic model_outputs();
        for (int i = 0; i < NDIG; i++) begin
            exp_dig[4*i +: 4] = com[i];
            exp_val[i]        = (com[i] != 4'hF);
        end
        exp_v = {exp_dig, exp_val, exp_nuevo, exp_err};
        got_v = {bus.digitos, bus.valido, bus.nuevo, bus.error_anodo};
    endtask

    task automatic model_apply();
        int ones;
        int idx;
        logic [3:0] c;
        exp_nuevo = 1'b0;
        exp_err   = 1'b0;
        if (p_en) begin
            ones = 0;
            idx  = 0;
            for (int i = 0; i < NDIG; i++) begin
                if (p_an[i]) begin
                    ones++;
                    idx = i;
                end
            end
            if (ones != 1) begin
                exp_err = 1'b1;
            end else begin
                c = ref_code(p_seg);
                if (run_len[idx] > 0 && run_val[idx] == c) begin
                    if (run_len[idx] < STABLE) begin
                        run_len[idx]++;
                        if (run_len[idx] == STABLE) begin
                            if (com[idx] != c) exp_nuevo = 1'b1;
                            com[idx] = c;
                        end
                    end
                end else begin
                    run_val[idx] = c;
                    run_len[idx] = 1;
                    if (STABLE == 1) begin
                        if (com[idx] != c) exp_nuevo = 1'b1;
                        com[idx] = c;
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, settle 1 time unit.
    task automatic cycle(input logic r, input logic en, input logic [6:0] seg, input logic [3:0] an);
        @(negedge clk);
        rst           = r;
        bus.sample_en = en;
        bus.segmentos = seg;
        bus.anodos    = an;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NDIG; i++) begin
                run_len[i] = 0;
                run_val[i] = 4'hF;
                com[i]     = 4'hF;
            end
            exp_nuevo = 1'b0;
            exp_err   = 1'b0;
            p_en      = 1'b0;
        end else begin
            model_apply();
            p_en  = en;
            p_seg = seg;
            p_an  = an;
        end
        #1;
        model_outputs();
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, SEG_TBL[3], 4'b0001);
        cycle(1'b1, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_digitos: got %h expected %h", bus.digitos, 16'hFFFF);
        end
        n_checks++;
        if (bus.valido !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valido: got %b expected %b", bus.valido, 4'b0000);
        end
        n_checks++;
        if (bus.nuevo !== 1'b0 || bus.error_anodo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got nuevo=%b err=%b expected 0 0", bus.nuevo, bus.error_anodo);
        end
    endtask

    task automatic test_first_commit();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, SEG_TBL[0], 4'b0001);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL first_commit_model k=%0d: got %h expected %h", k, got_v, exp_v);
            end
        end
        n_checks++;
        if (bus.valido[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL first_commit_early: got valido0=%b expected 0", bus.valido[0]);
        end
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos[3:0] !== 4'h0 || bus.valido[0] !== 1'b1 || bus.nuevo !== 1'b1) begin
            n_fail++;
            $display("FAIL first_commit: got dig0=%h val0=%b nuevo=%b expected 0 1 1",
                     bus.digitos[3:0], bus.valido[0], bus.nuevo);
        end
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.nuevo !== 1'b0) begin
            n_fail++;
            $display("FAIL first_commit_pulse_len: got nuevo=%b expected 0", bus.nuevo);
        end
    endtask

    task automatic test_streak();
        logic [6:0] seq [6];
        seq = '{SEG_TBL[5], SEG_TBL[5], SEG_TBL[8], SEG_TBL[5], SEG_TBL[5], SEG_TBL[5]};
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, seq[k], 4'b0100);
            // Gap with noise on the bus must not break the streak.
            if (k == 4) cycle(1'b0, 1'b0, SEG_TBL[8], 4'b0100);
            n_checks++;
            if (bus.valido[2] !== 1'b0 || bus.digitos[11:8] !== 4'hF) begin
                n_fail++;
                $display("FAIL streak_early k=%0d: got val2=%b dig2=%h expected 0 f",
                         k, bus.valido[2], bus.digitos[11:8]);
            end
        end
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos[11:8] !== 4'h5 || bus.valido[2] !== 1'b1 || bus.nuevo !== 1'b1) begin
            n_fail++;
            $display("FAIL streak_commit: got dig2=%h val2=%b nuevo=%b expected 5 1 1",
                     bus.digitos[11:8], bus.valido[2], bus.nuevo);
        end
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL streak_model: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_error_anodo();
        logic [3:0] an_bad [2];
        an_bad = '{4'b0011, 4'b0000};
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, SEG_TBL[1], an_bad[k]);
            cycle(1'b0, 1'b0, 7'd0, 4'b0000);
            n_checks++;
            if (bus.error_anodo !== 1'b1 || bus.nuevo !== 1'b0) begin
                n_fail++;
                $display("FAIL error_pulse k=%0d: got err=%b nuevo=%b expected 1 0",
                         k, bus.error_anodo, bus.nuevo);
            end
            n_checks++;
            if (bus.digitos !== 16'hF5F0 || bus.valido !== 4'b0101) begin
                n_fail++;
                $display("FAIL error_hold k=%0d: got %h/%b expected f5f0/0101",
                         k, bus.digitos, bus.valido);
            end
        end
        cycle(1'b0, 1'b0, SEG_TBL[1], 4'b0011);
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.error_anodo !== 1'b0) begin
            n_fail++;
            $display("FAIL error_unqualified: got err=%b expected 0", bus.error_anodo);
        end
    endtask

    task automatic test_guion_invalido();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, SEG_DASH, 4'b0010);
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos[7:4] !== 4'hA || bus.valido[1] !== 1'b1 || bus.nuevo !== 1'b1) begin
            n_fail++;
            $display("FAIL guion_commit: got dig1=%h val1=%b nuevo=%b expected a 1 1",
                     bus.digitos[7:4], bus.valido[1], bus.nuevo);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, SEG_BAD, 4'b0010);
        n_checks++;
        if (bus.digitos[7:4] !== 4'hA || bus.valido[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL invalido_hold: got dig1=%h val1=%b expected a 1",
                     bus.digitos[7:4], bus.valido[1]);
        end
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos[7:4] !== 4'hF || bus.valido[1] !== 1'b0 || bus.nuevo !== 1'b1) begin
            n_fail++;
            $display("FAIL invalido_commit: got dig1=%h val1=%b nuevo=%b expected f 0 1",
                     bus.digitos[7:4], bus.valido[1], bus.nuevo);
        end
    endtask

    task automatic test_reset_mid_capture();
        cycle(1'b0, 1'b1, SEG_TBL[7], 4'b1000);
        cycle(1'b0, 1'b1, SEG_TBL[7], 4'b1000);
        cycle(1'b1, 1'b1, SEG_TBL[7], 4'b1000);
        cycle(1'b0, 1'b1, SEG_TBL[7], 4'b1000);
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos !== 16'hFFFF || bus.valido !== 4'b0000 || bus.nuevo !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_nocommit: got %h/%b nuevo=%b expected ffff/0000 0",
                     bus.digitos, bus.valido, bus.nuevo);
        end
        cycle(1'b0, 1'b1, SEG_TBL[7], 4'b1000);
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.valido[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_two_fresh: got val3=%b expected 0", bus.valido[3]);
        end
        cycle(1'b0, 1'b1, SEG_TBL[7], 4'b1000);
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos[15:12] !== 4'h7 || bus.valido[3] !== 1'b1 || bus.nuevo !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_three_fresh: got dig3=%h val3=%b nuevo=%b expected 7 1 1",
                     bus.digitos[15:12], bus.valido[3], bus.nuevo);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NDIG; i++) begin
                cycle(1'b0, 1'b1, SEG_TBL[i+1], 4'(1 << i));
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_model r=%0d i=%0d: got %h expected %h", r, i, got_v, exp_v);
                end
            end
        end
        cycle(1'b0, 1'b0, 7'd0, 4'b0000);
        n_checks++;
        if (bus.digitos !== 16'h4321 || bus.valido !== 4'b1111) begin
            n_fail++;
            $display("FAIL b2b_final: got %h/%b expected 4321/1111", bus.digitos, bus.valido);
        end
    endtask

    task automatic test_random();
        logic [6:0] last_seg [NDIG];
        logic [6:0] seg;
        logic [3:0] an;
        logic       en;
        logic       r;
        int         d;
        int         pick;
        for (int i = 0; i < NDIG; i++) last_seg[i] = SEG_TBL[i];
        for (int n = 0; n < 500; n++) begin
            r  = ($urandom_range(63) == 0);
            en = ($urandom_range(3) != 0);
            d  = int'($urandom_range(NDIG - 1));
            if ($urandom_range(7) == 0) an = 4'($urandom);
            else                        an = 4'(1 << d);
            if ($urandom_range(9) < 6) begin
                seg = last_seg[d];
            end else begin
                pick = int'($urandom_range(11));
                if (pick < 10)       seg = SEG_TBL[pick];
                else if (pick == 10) seg = SEG_DASH;
                else                 seg = 7'($urandom);
                last_seg[d] = seg;
            end
            cycle(r, en, seg, an);
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random n=%0d: got %h expected %h", n, got_v, exp_v);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.sample_en = 1'b0;
        bus.segmentos = 7'd0;
        bus.anodos    = 4'd0;
        p_en          = 1'b0;
        p_seg         = 7'd0;
        p_an          = 4'd0;
        exp_nuevo     = 1'b0;
        exp_err       = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            run_len[i] = 0;
            run_val[i] = 4'hF;
            com[i]     = 4'hF;
        end

        test_reset();
        test_first_commit();
        test_streak();
        test_error_anodo();
        test_guion_invalido();
        test_reset_mid_capture();
        test_back_to_back();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
